key_evt_arbiter: RTL and testbench

KEY_EVT_ARBITER -- requirements
Module: key_evt_arbiter

---
 rtl/key_evt_pkg.sv | 28 ++
 rtl/key_evt_reg.sv | 66 ++++++
 rtl/key_evt_arbiter.sv | 123 ++++++++++++
 tb/tb_key_evt_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event arbiter.
//   state_e     : FSM state encoding (IDLE, PRESS, HOLD, WAIT_REL)
//   EVT_*       : event-type codes driven on evt_type
//   lowest_key  : lowest-index asserted bit of a 4-bit key_flag vector
package key_evt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS    = 2'd1,
    ST_HOLD     = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  localparam logic [1:0] EVT_SHORT  = 2'b00;
  localparam logic [1:0] EVT_LONG   = 2'b01;
  localparam logic [1:0] EVT_REPEAT = 2'b10;

  function automatic logic [1:0] lowest_key(input logic [3:0] flags);
    logic [1:0] idx;
    idx = '0;
    if (flags[0])      idx = 2'd0;
    else if (flags[1]) idx = 2'd1;
    else if (flags[2]) idx = 2'd2;
    else if (flags[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/key_evt_reg.sv
// One-entry valid/ready output register for key events.
//   clk, rst          : clock, asynchronous active-high reset
//   load              : a new event is offered this cycle
//   key_in, type_in   : key index and type of the offered event
//   ready             : consumer accepts the held event when valid && ready
//   valid             : an event is held
//   key_out, type_out : held event contents
//   drop              : one-cycle pulse when an offered event is discarded
module key_evt_reg
  import key_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] key_in,
  input  logic [1:0] type_in,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] key_out,
  output logic [1:0] type_out,
  output logic       drop
);

  logic       valid_q, valid_d;
  logic [1:0] key_q, key_d;
  logic [1:0] type_q, type_d;
  logic       drop_q, drop_d;

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    type_d  = type_q;
    drop_d  = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (load) begin
      // A stalled held event wins; the newcomer is discarded.
      if (valid_q && !ready) begin
        drop_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        key_d   = key_in;
        type_d  = type_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      type_q  <= EVT_SHORT;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
      type_q  <= type_d;
      drop_q  <= drop_d;
    end
  end

  assign valid    = valid_q;
  assign key_out  = key_q;
  assign type_out = type_q;
  assign drop     = drop_q;

endmodule

// File: rtl/key_evt_arbiter.sv
// Key event arbiter: tracks one key at a time and classifies its press as
// SHORT, LONG or (optionally) auto-REPEAT, presenting events on a
// one-entry valid/ready output.
//   clk, rst   : clock, asynchronous active-high reset
//   key_flag   : per-key one-cycle press pulses
//   key_state  : per-key debounced level (0 = pressed)
//   evt_valid/evt_ready/evt_key/evt_type : event output handshake
//   busy       : FSM not idle
//   evt_drop   : pulse when an event is discarded under backpressure
// Build option: define KEY_EVT_REPEAT_EN to compile in HOLD / REPEAT events.
module key_evt_arbiter
  import key_evt_pkg::*;
#(
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_flag,
  input  logic [3:0] key_state,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic [1:0] evt_type,
  output logic       busy,
  output logic       evt_drop
);

  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_CNT - 1);
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TH = CNT_W'(REPEAT_CNT - 1);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       key_q, key_d;
  logic             load;
  logic [1:0]       load_type;
  logic             rel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    load      = 1'b0;
    load_type = EVT_SHORT;
    rel       = key_state[key_q];
    // Release is tested before the threshold so it wins a same-cycle tie.
    case (state_q)
      ST_IDLE: begin
        if (|key_flag) begin
          key_d   = lowest_key(key_flag);
          cnt_d   = '0;
          state_d = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (rel) begin
          load      = 1'b1;
          load_type = EVT_SHORT;
          state_d   = ST_IDLE;
        end else if (cnt_q == LONG_TH) begin
          load      = 1'b1;
          load_type = EVT_LONG;
          cnt_d     = '0;
`ifdef KEY_EVT_REPEAT_EN
          state_d   = ST_HOLD;
`else
          state_d   = ST_WAIT_REL;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef KEY_EVT_REPEAT_EN
      ST_HOLD: begin
        if (rel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == REPEAT_TH) begin
          load      = 1'b1;
          load_type = EVT_REPEAT;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_WAIT_REL: begin
        if (rel) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  key_evt_reg u_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .key_in   (key_q),
    .type_in  (load_type),
    .ready    (evt_ready),
    .valid    (evt_valid),
    .key_out  (evt_key),
    .type_out (evt_type),
    .drop     (evt_drop)
  );

endmodule

// File: tb/tb_key_evt_arbiter.sv
module tb_key_evt_arbiter;
  import key_evt_pkg::*;

  localparam int LONG_CNT   = 8;
  localparam int REPEAT_CNT = 4;
  localparam int CNT_W      = 4;
`ifdef KEY_EVT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_flag;
  logic [3:0] key_state;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       busy;
  logic       evt_drop;

  key_evt_arbiter #(
    .LONG_CNT   (LONG_CNT),
    .REPEAT_CNT (REPEAT_CNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_flag  (key_flag),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .busy      (busy),
    .evt_drop  (evt_drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is tracked by how many cycles it has been held.
  // LONG fires at exactly LONG_CNT held cycles, REPEAT every REPEAT_CNT after.
  bit         trk = 0;
  logic [1:0] tkey = '0;
  int         held = 0;
  bit         m_valid = 0;
  bit         m_busy = 0;
  bit         m_drop = 0;
  logic [3:0] exp_q[$];

  task automatic model_reset();
    trk = 0; tkey = '0; held = 0;
    m_valid = 0; m_busy = 0; m_drop = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit         emit;
    logic [1:0] ety;
    emit = 0;
    ety  = EVT_SHORT;
    if (!trk) begin
      if (key_flag != 4'h0) begin
        trk  = 1;
        held = 0;
        for (int i = 3; i >= 0; i--)
          if (key_flag[i]) tkey = 2'(i);
      end
    end else if (key_state[tkey]) begin
      if (held < LONG_CNT) emit = 1;
      trk = 0;
    end else begin
      held++;
      if (held == LONG_CNT) begin
        emit = 1; ety = EVT_LONG;
      end else if (REP_EN && held > LONG_CNT && (held - LONG_CNT) % REPEAT_CNT == 0) begin
        emit = 1; ety = EVT_REPEAT;
      end
    end
    m_drop = 0;
    if (emit && m_valid && !evt_ready) begin
      m_drop = 1;
    end else if (emit) begin
      m_valid = 1;
      exp_q.push_back({tkey, ety});
    end else if (m_valid && evt_ready) begin
      m_valid = 0;
    end
    m_busy = trk;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Monitor: per-cycle status checks, event contents popped on each accept.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("evt_valid", 32'(evt_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_busy));
        check("evt_drop", 32'(evt_drop), 32'(m_drop));
        if (evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 32'({evt_key, evt_type}), 32'hFF);
          end else begin
            e = exp_q.pop_front();
            check("evt_key", 32'(evt_key), 32'(e[3:2]));
            check("evt_type", 32'(evt_type), 32'(e[1:0]));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int k, input int hold);
    key_flag[k]  = 1'b1;
    key_state[k] = 1'b0;
    tick(1);
    key_flag = '0;
    tick(hold);
    key_state[k] = 1'b1;
    tick(1);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_key", 32'(evt_key), 32'd0);
    check("rst_type", 32'(evt_type), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(evt_drop), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    key_flag = '0;
    key_state = 4'hF;
    evt_ready = 1'b1;
    #1 check_reset_outputs();
    tick(2);
    rst = 1'b0;
    tick(2);

    // Short press on key 2
    press(2, 3);
    tick(4);
    // Long hold on key 1 (LONG then REPEATs when enabled)
    press(1, 20);
    tick(4);
    // Simultaneous flags pick key 0; a later flag[3] is ignored
    key_flag = 4'b1001;
    key_state[0] = 1'b0;
    key_state[3] = 1'b0;
    tick(1);
    key_flag = '0;
    tick(2);
    key_flag[3] = 1'b1;
    tick(1);
    key_flag = '0;
    tick(2);
    key_state = 4'hF;
    tick(4);
    // Backpressure: second SHORT dropped, first delivered
    evt_ready = 1'b0;
    press(0, 2);
    tick(2);
    press(1, 2);
    tick(3);
    evt_ready = 1'b1;
    tick(3);
    // Release on the threshold cycle, and one cycle later
    press(3, LONG_CNT - 1);
    tick(3);
    press(3, LONG_CNT);
    tick(3);
    // Reset mid-hold with a pending event, key kept held afterwards
    evt_ready = 1'b0;
    key_flag[3] = 1'b1;
    key_state[3] = 1'b0;
    tick(1);
    key_flag = '0;
    tick(LONG_CNT + 6);
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    tick(2);
    rst = 1'b0;
    evt_ready = 1'b1;
    tick(20);
    key_state = 4'hF;
    tick(3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(11) == 0) key_state[k] = ~key_state[k];
      key_flag  = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
      evt_ready = ($urandom_range(3) != 0);
      tick(1);
    end

    key_flag = '0;
    key_state = 4'hF;
    evt_ready = 1'b1;
    tick(20);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
